regincr_rr_sched: RTL

//  Shares one NSTAGES-deep registered-incrementer pipeline among NREQ requesters.
//  - Round-robin arbitration of val/rdy requests; each accepted message carries a requester-ID tag.
//  - Each result is steered back to its requester through a per-requester response queue.
//  - Per-requester credit flow control means a stalled sink never blocks the other requesters.

---
 rtl/regincr_sched_pkg.sv | 22 ++
 rtl/regincr_rr_fifo.sv | 71 +++++++
 rtl/regincr_rr_sched.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/regincr_sched_pkg.sv
// Shared constants, the requester-ID width helper and the pipeline entry type
// for the round-robin registered-incrementer scheduler.
package regincr_sched_pkg;

  localparam int DEF_NREQ    = 2;
  localparam int DEF_NBITS   = 8;
  localparam int DEF_NSTAGES = 2;
  localparam int DEF_QDEPTH  = 4;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_ID_W = id_width(DEF_NREQ);

  typedef struct packed {
    logic                 val;
    logic [DEF_ID_W-1:0]  id;
    logic [DEF_NBITS-1:0] data;
  } pipe_entry_t;

endpackage

// File: rtl/regincr_rr_fifo.sv
// Circular response queue; the head reads as zero while empty so the shared
// response bus stays quiet when nothing is pending.
module regincr_rr_fifo #(
  parameter int NBITS = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enq,
  input  logic [NBITS-1:0] enq_data,
  input  logic             deq,
  output logic [NBITS-1:0] deq_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [NBITS-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_enq_s;
  logic             do_deq_s;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full     = (count_r == CW'(DEPTH));
  assign empty    = (count_r == '0);
  assign do_enq_s = enq && !full;
  assign do_deq_s = deq && !empty;

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      wr_ptr_r <= do_enq_s ? next_ptr(wr_ptr_r) : wr_ptr_r;
      rd_ptr_r <= do_deq_s ? next_ptr(rd_ptr_r) : rd_ptr_r;
      case ({do_enq_s, do_deq_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // storage array
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (do_enq_s) begin
      mem_r[wr_ptr_r] <= enq_data;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // head presentation
  always_comb begin
    deq_data = '0;
    if (empty) deq_data = '0;
    else       deq_data = mem_r[rd_ptr_r];
  end

endmodule

// File: rtl/regincr_rr_sched.sv
// One registered-incrementer pipeline shared by NREQ requesters: round-robin
// arbitration gated by per-requester credits, ID-tagged stages, response queues.
module regincr_rr_sched
  import regincr_sched_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int NBITS   = DEF_NBITS,
  parameter int NSTAGES = DEF_NSTAGES,
  parameter int QDEPTH  = DEF_QDEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_val,
  output logic [NREQ-1:0]       req_rdy,
  input  logic [NREQ*NBITS-1:0] req_msg,
  output logic [NREQ-1:0]       resp_val,
  input  logic [NREQ-1:0]       resp_rdy,
  output logic [NREQ*NBITS-1:0] resp_msg
);

  localparam int ID_W = id_width(NREQ);
  localparam int CW   = $clog2(QDEPTH + 1);

  typedef struct packed {
    logic             val;
    logic [ID_W-1:0]  id;
    logic [NBITS-1:0] data;
  } stage_t;

  logic [ID_W-1:0]  rr_ptr_r;
  logic [CW-1:0]    credit_r [NREQ];
  stage_t           pipe_r [NSTAGES];
  logic [NREQ-1:0]  grant_s;
  logic [NREQ-1:0]  enq_s;
  logic [NREQ-1:0]  deq_s;
  logic [NREQ-1:0]  full_s;
  logic [NREQ-1:0]  empty_s;
  logic             grant_any_s;
  logic [ID_W-1:0]  grant_id_s;
  logic [NBITS-1:0] grant_msg_s;
  logic [ID_W:0]    sum_s;
  logic [ID_W-1:0]  idx_s;

  // round-robin search from rr_ptr, skipping requesters without credit
  always_comb begin
    grant_s     = '0;
    grant_any_s = 1'b0;
    grant_id_s  = '0;
    sum_s       = '0;
    idx_s       = '0;
    for (int off = 0; off < NREQ; off++) begin
      sum_s = {1'b0, rr_ptr_r} + (ID_W + 1)'(off);
      if (sum_s >= (ID_W + 1)'(NREQ)) sum_s = sum_s - (ID_W + 1)'(NREQ);
      else                            sum_s = sum_s;
      idx_s = sum_s[ID_W-1:0];
      if (!grant_any_s && req_val[idx_s] && (credit_r[idx_s] != '0)) begin
        grant_any_s    = 1'b1;
        grant_id_s     = idx_s;
        grant_s[idx_s] = 1'b1;
      end else begin
        grant_any_s = grant_any_s;
      end
    end
  end

  // ready is the grant, forced low while reset is held
  always_comb begin
    req_rdy = '0;
    if (reset) req_rdy = '0;
    else       req_rdy = grant_s;
  end

  // winning message select
  always_comb begin
    grant_msg_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_s[i]) grant_msg_s = req_msg[i*NBITS +: NBITS];
      else            grant_msg_s = grant_msg_s;
    end
  end

  // arbitration pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_r <= '0;
    end else if (grant_any_s) begin
      rr_ptr_r <= (grant_id_s == ID_W'(NREQ - 1)) ? '0 : grant_id_s + ID_W'(1);
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // credits reserve queue space at grant time, so the pipeline never stalls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) credit_r[i] <= CW'(QDEPTH);
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        case ({grant_s[i], deq_s[i]})
          2'b10:   credit_r[i] <= credit_r[i] - CW'(1);
          2'b01:   credit_r[i] <= credit_r[i] + CW'(1);
          default: credit_r[i] <= credit_r[i];
        endcase
      end
    end
  end

  // incrementer stages, always advancing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NSTAGES; s++) pipe_r[s] <= '0;
    end else begin
      pipe_r[0] <= '{val: grant_any_s, id: grant_id_s, data: grant_msg_s + NBITS'(1)};
      for (int s = 1; s < NSTAGES; s++) begin
        pipe_r[s] <= '{val: pipe_r[s-1].val, id: pipe_r[s-1].id,
                       data: pipe_r[s-1].data + NBITS'(1)};
      end
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_q
    assign enq_s[g]    = pipe_r[NSTAGES-1].val && (pipe_r[NSTAGES-1].id == ID_W'(g)) && !full_s[g];
    assign resp_val[g] = !empty_s[g];
    assign deq_s[g]    = !empty_s[g] && resp_rdy[g];

    regincr_rr_fifo #(
      .NBITS (NBITS),
      .DEPTH (QDEPTH)
    ) u_q (
      .clk      (clk),
      .reset    (reset),
      .enq      (enq_s[g]),
      .enq_data (pipe_r[NSTAGES-1].data),
      .deq      (deq_s[g]),
      .deq_data (resp_msg[g*NBITS +: NBITS]),
      .full     (full_s[g]),
      .empty    (empty_s[g])
    );
  end

endmodule
